zipdbg_sequencer: RTL and testbench
===================================

// Module: zipdbg_sequencer
// PURPOSE
//  Debug-port controller for the ZipBones debug slave (2-word port: addr0=ctrl, addr1=data).
//  Turns one host request (read/write CPU register N) into the full bus sequence:
//    read ctrl, halt CPU + set reg address, poll until debug-ready, data access, restore run state.
//  Sits between a host bridge (UART/JTAG-to-bus) and the debug wishbone slave. One request in flight at a time.
// PARAMETERS
//  TIMEOUT_LG  10  log2 of the per-transaction ack timeout, in clocks (also bounds the POLL state)
//  POLL_MAX    15  max ctrl re-reads in POLL before an error is flagged (4-bit counter)
// PORTS
//  i_clk        in   1   clock
//  i_rst        in   1   reset, synchronous, active-high
//  i_req        in   1   request strobe; accepted only when o_busy=0
//  i_req_we     in   1   1=write CPU register, 0=read
//  i_req_reg    in   5   CPU register index (0..31)
//  i_req_data   in   32  write data
//  i_keep_halt  in   1   1=leave CPU halted after access regardless of prior state
//  o_busy       out  1   sequence in progress
//  o_done       out  1   1-cycle pulse at sequence end
//  o_err        out  1   valid with o_done: timeout or poll exhaustion
//  o_rdata      out  32  register read data, valid with o_done (held until next accept)
//  o_dbg_cyc    out  1   debug wishbone master: cycle
//  o_dbg_stb    out  1   strobe
//  o_dbg_we     out  1   write enable
//  o_dbg_addr   out  1   0=ctrl word, 1=data word
//  o_dbg_data   out  32  write data
//  i_dbg_ack    in   1   ack
//  i_dbg_stall  in   1   stall
//  i_dbg_data   in   32  read data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. i_rst mid-sequence aborts at once: cyc/stb drop in that
//   cycle, no o_done; the slave must tolerate the dropped cycle.
//  Bus rules: one transfer per cyc. stb held with cyc until the first cycle with !i_dbg_stall, then stb=0.
//   cyc held until i_dbg_ack. Addr/we/data are stable from stb rise until ack. There is >=1 idle cycle (cyc=0)
//   between transfers. An ack while stb is still high (same cycle stall drops) completes the transfer.
//  Timeout: a TIMEOUT_LG-bit counter clears at each transfer start and increments while cyc=1. On wrap:
//   drop cyc, set o_err, go to DONE. The restore write is skipped on error, so the CPU stays halted.
//  Ctrl word constants: HALT=bit10, STALLN=bit9 (1 = debug port ready), RESET=bit6, STEP=bit8, CLRPF=bit11.
//   This block never sets RESET, STEP or CLRPF.
//  FSM:
//   IDLE     : on i_req && !o_busy, latch req fields, o_busy=1 -> RD_CTL
//   RD_CTL   : read addr0; on ack latch was_halt=i_dbg_data[10] -> WR_HALT
//   WR_HALT  : write addr0 data=32'h400|{27'h0,reg} -> POLL
//   POLL     : read addr0; on ack: bit9=1 -> DATA; else poll_cnt++; poll_cnt==POLL_MAX -> err, DONE
//   DATA     : addr1, we=req_we, data=req_data; on ack (read) latch o_rdata=i_dbg_data -> RESTORE
//   RESTORE  : if (!was_halt && !i_keep_halt) write addr0 data={27'h0,reg} (resume), else skip -> DONE
//   DONE     : o_done=1 for one cycle, o_busy=0 -> IDLE
//  i_keep_halt is sampled at accept. An i_req while busy is ignored (no queueing).
//  The latency of a read with no stall and 1-cycle acks is fixed; the bench measures it and locks it as the
//   reference. Each transfer takes 3 cycles (stb, ack, idle).
// STRUCTURE
//  Shared defines file zipdbg_defs.v: ctrl bit positions (HALT, STALLN, RESET, STEP, CLRPF), ADDR_CTL/ADDR_DATA,
//   state encodings. zipbones and the host bridge use the same file.
//  Sub-module zipdbg_wbxact: single-transfer pipelined-wishbone master with the timeout counter.
//   Interfaces: start/we/addr/data in; done/err/rdata out. The FSM in the top level sequences it.
// TESTING
//  1 Read reg 5, CPU running (ctrl reads 0x200), 1-cycle ack -> writes 0x405, then data read, then writes
//    0x005; o_rdata=slave value, o_err=0.
//  2 Write reg 3 = 0xDEADBEEF with CPU already halted (ctrl bit10=1) -> addr1 write carries 0xDEADBEEF,
//    no resume write, o_done pulses.
//  3 POLL: slave returns bit9=0 for 3 reads then 1 -> exactly 4 POLL reads; POLL_MAX=2 with bit9 stuck 0
//    -> o_err=1, no DATA or resume transfer.
//  4 Slave stalls DATA stb for 7 cycles -> stb/addr/data stable throughout; never 2 stbs per cyc.
//  5 Slave never acks -> cyc drops after 2^TIMEOUT_LG cycles, o_err=1, o_done=1.
//  6 i_rst asserted in POLL -> next cycle cyc=stb=busy=0, no done; new i_req afterwards runs cleanly.

Source files
------------

// File: rtl/zipdbg_sequencer_pkg.sv
// Shared definitions for the ZipBones debug-port sequencer: ctrl word bit positions,
// debug port addresses, sequencer states and the single-transfer request record.
package zipdbg_sequencer_pkg;

   localparam int CTL_RESET  = 6;
   localparam int CTL_STEP   = 8;
   localparam int CTL_STALLN = 9;
   localparam int CTL_HALT   = 10;
   localparam int CTL_CLRPF  = 11;

   localparam logic ADDR_CTL  = 1'b0;
   localparam logic ADDR_DATA = 1'b1;

   // Bits this controller must never drive high in a ctrl write.
   localparam logic [31:0] CTL_NEVER_SET = (32'd1 << CTL_RESET) | (32'd1 << CTL_STEP)
                                         | (32'd1 << CTL_CLRPF);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_CTL  = 3'd1,
      ST_WR_HALT = 3'd2,
      ST_POLL    = 3'd3,
      ST_DATA    = 3'd4,
      ST_RESTORE = 3'd5,
      ST_DONE    = 3'd6
   } seq_state_t;

   typedef struct packed {
      logic        we;
      logic        addr;
      logic [31:0] data;
   } xact_req_t;

   function automatic logic [31:0] ctl_word(input logic halt, input logic [4:0] regn);
      logic [31:0] w;
      w           = {27'h0, regn};
      w[CTL_HALT] = halt;
      return w & ~CTL_NEVER_SET;
   endfunction

endpackage

// File: rtl/zipdbg_sequencer_wbxact.sv
// Single-transfer pipelined wishbone master: one stb per cyc, cyc held until ack,
// and a free-running timeout that abandons the transfer after 2^TIMEOUT_LG cycles.
module zipdbg_sequencer_wbxact
   import zipdbg_sequencer_pkg::*;
#(
   parameter int TIMEOUT_LG = 10
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        start,
   input  xact_req_t   req,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        cyc,
   output logic        stb,
   output logic        bus_we,
   output logic        bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        ack,
   input  logic        stall,
   input  logic [31:0] bus_rdata
);

   logic [TIMEOUT_LG-1:0] timer;
   logic                  timed_out;

   assign timed_out = &timer;

   // start is only honoured while idle, so done (cyc=0) always separates two transfers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cyc       <= 1'b0;
         stb       <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         bus_we    <= 1'b0;
         bus_addr  <= 1'b0;
         bus_wdata <= '0;
         timer     <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (!cyc) begin
            if (start) begin
               cyc       <= 1'b1;
               stb       <= 1'b1;
               bus_we    <= req.we;
               bus_addr  <= req.addr;
               bus_wdata <= req.data;
               timer     <= '0;
            end
         end else if (ack) begin
            cyc   <= 1'b0;
            stb   <= 1'b0;
            done  <= 1'b1;
            rdata <= bus_rdata;
         end else if (timed_out) begin
            cyc  <= 1'b0;
            stb  <= 1'b0;
            done <= 1'b1;
            err  <= 1'b1;
         end else begin
            timer <= timer + 1'b1;
            if (stb && !stall) stb <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/zipdbg_sequencer.sv
// Debug-port sequencer: turns one host register read/write into the ZipBones bus sequence
// read ctrl, halt + select reg, poll ready, data access, optional resume.
module zipdbg_sequencer
   import zipdbg_sequencer_pkg::*;
#(
   parameter int TIMEOUT_LG = 10,
   parameter int POLL_MAX   = 15
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic        i_req_we,
   input  logic [4:0]  i_req_reg,
   input  logic [31:0] i_req_data,
   input  logic        i_keep_halt,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [31:0] o_rdata,
   output logic        o_dbg_cyc,
   output logic        o_dbg_stb,
   output logic        o_dbg_we,
   output logic        o_dbg_addr,
   output logic [31:0] o_dbg_data,
   input  logic        i_dbg_ack,
   input  logic        i_dbg_stall,
   input  logic [31:0] i_dbg_data,
   output seq_state_t  seq_state
);

   seq_state_t  state, next;
   logic        start;
   xact_req_t   xreq;
   logic        x_done, x_err, x_cyc, x_stb;
   logic [31:0] x_rdata;

   logic        req_we, keep_halt, was_halt, err_q;
   logic [4:0]  req_reg;
   logic [31:0] req_data, rdata_q;
   logic [3:0]  poll_cnt, poll_next;
   logic        poll_exhausted, accept, resume;

   assign accept         = i_req && (state == ST_IDLE || state == ST_DONE);
   assign resume         = !was_halt && !keep_halt;
   assign poll_next      = poll_cnt + 4'd1;
   assign poll_exhausted = (poll_next == 4'(POLL_MAX));

   always_comb begin
      next  = state;
      start = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            next = ST_IDLE;
            if (accept) begin
               next  = ST_RD_CTL;
               start = 1'b1;
            end
         end
         ST_RD_CTL: if (x_done) begin
            if (x_err) next = ST_DONE;
            else begin
               next  = ST_WR_HALT;
               start = 1'b1;
            end
         end
         ST_WR_HALT: if (x_done) begin
            if (x_err) next = ST_DONE;
            else begin
               next  = ST_POLL;
               start = 1'b1;
            end
         end
         ST_POLL: if (x_done) begin
            if (x_err) next = ST_DONE;
            else if (x_rdata[CTL_STALLN]) begin
               next  = ST_DATA;
               start = 1'b1;
            end else if (poll_exhausted) next = ST_DONE;
            else start = 1'b1;
         end
         ST_DATA: if (x_done) begin
            if (x_err) next = ST_DONE;
            else if (resume) begin
               next  = ST_RESTORE;
               start = 1'b1;
            end else next = ST_DONE;
         end
         ST_RESTORE: if (x_done) next = ST_DONE;
         default: next = ST_IDLE;
      endcase
   end

   // Transfer fields follow the state being entered, so they are valid alongside start.
   always_comb begin
      xreq.we   = 1'b0;
      xreq.addr = ADDR_CTL;
      xreq.data = '0;
      case (next)
         ST_WR_HALT: begin
            xreq.we   = 1'b1;
            xreq.data = ctl_word(1'b1, req_reg);
         end
         ST_DATA: begin
            xreq.we   = req_we;
            xreq.addr = ADDR_DATA;
            xreq.data = req_data;
         end
         ST_RESTORE: begin
            xreq.we   = 1'b1;
            xreq.data = ctl_word(1'b0, req_reg);
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         req_we    <= 1'b0;
         req_reg   <= '0;
         req_data  <= '0;
         keep_halt <= 1'b0;
         was_halt  <= 1'b0;
         poll_cnt  <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state <= next;
         if (accept) begin
            req_we    <= i_req_we;
            req_reg   <= i_req_reg;
            req_data  <= i_req_data;
            keep_halt <= i_keep_halt;
            was_halt  <= 1'b0;
            poll_cnt  <= '0;
            err_q     <= 1'b0;
         end
         if (x_done) begin
            if (x_err) err_q <= 1'b1;
            else begin
               case (state)
                  ST_RD_CTL: was_halt <= x_rdata[CTL_HALT];
                  ST_POLL: if (!x_rdata[CTL_STALLN]) begin
                     poll_cnt <= poll_next;
                     if (poll_exhausted) err_q <= 1'b1;
                  end
                  ST_DATA: if (!req_we) rdata_q <= x_rdata;
                  default: ;
               endcase
            end
         end
      end
   end

   zipdbg_sequencer_wbxact #(.TIMEOUT_LG(TIMEOUT_LG)) u_xact (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .start     (start),
      .req       (xreq),
      .done      (x_done),
      .err       (x_err),
      .rdata     (x_rdata),
      .cyc       (x_cyc),
      .stb       (x_stb),
      .bus_we    (o_dbg_we),
      .bus_addr  (o_dbg_addr),
      .bus_wdata (o_dbg_data),
      .ack       (i_dbg_ack),
      .stall     (i_dbg_stall),
      .bus_rdata (i_dbg_data)
   );

   // Reset drops the bus cycle in the same clock it is asserted.
   assign o_dbg_cyc = x_cyc && !i_rst;
   assign o_dbg_stb = x_stb && !i_rst;
   assign o_busy    = (state != ST_IDLE) && (state != ST_DONE);
   assign o_done    = (state == ST_DONE);
   assign o_err     = o_done && err_q;
   assign o_rdata   = rdata_q;
   assign seq_state = state;

endmodule

// File: tb/tb_zipdbg_sequencer.sv
// Bench for zipdbg_sequencer: behavioural ZipBones debug slave plus a request-level model
// that predicts the bus transfer list, latency, error flag and read data of each request.
module tb_zipdbg_sequencer;
   import zipdbg_sequencer_pkg::*;

   localparam int TIMEOUT_LG = 10;
   localparam int POLL_MAX   = 4;

   logic        clk = 1'b0;
   logic        i_rst, i_req, i_req_we, i_keep_halt;
   logic [4:0]  i_req_reg;
   logic [31:0] i_req_data;
   logic        o_busy, o_done, o_err;
   logic [31:0] o_rdata;
   logic        o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr;
   logic [31:0] o_dbg_data;
   logic        i_dbg_ack, i_dbg_stall;
   logic [31:0] i_dbg_data;
   seq_state_t  seq_state;

   zipdbg_sequencer #(.TIMEOUT_LG(TIMEOUT_LG), .POLL_MAX(POLL_MAX)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_req_we(i_req_we), .i_req_reg(i_req_reg),
      .i_req_data(i_req_data), .i_keep_halt(i_keep_halt), .o_busy(o_busy), .o_done(o_done),
      .o_err(o_err), .o_rdata(o_rdata), .o_dbg_cyc(o_dbg_cyc), .o_dbg_stb(o_dbg_stb),
      .o_dbg_we(o_dbg_we), .o_dbg_addr(o_dbg_addr), .o_dbg_data(o_dbg_data),
      .i_dbg_ack(i_dbg_ack), .i_dbg_stall(i_dbg_stall), .i_dbg_data(i_dbg_data),
      .seq_state(seq_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave-side CPU state (environment) and request-level model state (expectations).
   logic [31:0] cpu_regs [32];
   logic        cpu_halt = 1'b0;
   logic [4:0]  cpu_sel = '0;
   int          nr_cfg = 0, nr_left = 0, data_stall_cfg = 0, cyc_len_last = 0;
   bit          noack = 1'b0;
   logic [33:0] act_q[$];
   logic [33:0] exp_q[$];
   logic [31:0] model_regs [32];
   bit          model_halt = 1'b0;

   // Debug slave: stalls data-word strobes on request, acks one cycle after accepting stb.
   initial begin
      bit          pending = 1'b0, held_valid = 1'b0, stalln;
      logic [31:0] resp = '0;
      logic [33:0] held = '0;
      int          stall_left = 0, cyc_len = 0, n_acc = 0;
      i_dbg_ack = 1'b0; i_dbg_stall = 1'b0; i_dbg_data = '0;
      forever begin
         @(posedge clk); #1;
         i_dbg_ack = 1'b0; i_dbg_stall = 1'b0;
         if (!o_dbg_cyc) begin
            if (cyc_len > 0) cyc_len_last = cyc_len;
            pending = 1'b0; cyc_len = 0; n_acc = 0; held_valid = 1'b0;
            stall_left = data_stall_cfg;
         end else begin
            cyc_len++;
            if (held_valid) check("bus_stable", {o_dbg_we, o_dbg_addr, o_dbg_data}, held);
            if (pending && !noack) begin
               i_dbg_ack = 1'b1; i_dbg_data = resp; pending = 1'b0;
            end
            if (o_dbg_stb) begin
               if (!held_valid) begin
                  held = {o_dbg_we, o_dbg_addr, o_dbg_data}; held_valid = 1'b1;
               end
               if (o_dbg_addr == ADDR_DATA && stall_left > 0) begin
                  i_dbg_stall = 1'b1; stall_left--;
               end else begin
                  check("one_stb_per_cyc", n_acc, 0);
                  n_acc++; pending = 1'b1;
                  if (o_dbg_we) begin
                     if (o_dbg_addr == ADDR_CTL) begin
                        cpu_halt = o_dbg_data[10]; cpu_sel = o_dbg_data[4:0];
                        if (o_dbg_data[10]) nr_left = nr_cfg;
                     end else cpu_regs[cpu_sel] = o_dbg_data;
                     act_q.push_back({1'b1, o_dbg_addr, o_dbg_data});
                  end else begin
                     if (o_dbg_addr == ADDR_CTL) begin
                        stalln = (nr_left == 0);
                        if (nr_left > 0) nr_left--;
                        resp = {21'h0, cpu_halt, stalln, 9'h0};
                     end else resp = cpu_regs[cpu_sel];
                     act_q.push_back({1'b0, o_dbg_addr, 32'h0});
                  end
               end
            end
         end
      end
   end

   task automatic run_req(input bit we, input logic [4:0] r, input logic [31:0] d, input bit keep,
                          input int nr, input int stall, input bit na, input bit poke);
      bit          was, exp_err, got_done;
      int          polls, lat, exp_lat, stall_used;
      logic [31:0] exp_rdata;
      exp_q.delete(); act_q.delete();
      was = model_halt; exp_err = 1'b0; exp_rdata = '0; stall_used = 0;
      exp_q.push_back({1'b0, ADDR_CTL, 32'h0});
      if (na) exp_err = 1'b1;
      else begin
         exp_q.push_back({1'b1, ADDR_CTL, 32'h400 | 32'(r)});
         polls = (nr < POLL_MAX) ? nr + 1 : POLL_MAX;
         repeat (polls) exp_q.push_back({1'b0, ADDR_CTL, 32'h0});
         model_halt = 1'b1;
         if (nr >= POLL_MAX) exp_err = 1'b1;
         else begin
            stall_used = stall;
            exp_q.push_back({we, ADDR_DATA, we ? d : 32'h0});
            if (we) model_regs[r] = d;
            else exp_rdata = model_regs[r];
            if (!was && !keep) begin
               exp_q.push_back({1'b1, ADDR_CTL, 32'(r)});
               model_halt = 1'b0;
            end
         end
      end
      exp_lat = na ? (1 << TIMEOUT_LG) + 2 : 3 * exp_q.size() + 1 + stall_used;

      nr_cfg = nr; data_stall_cfg = stall; noack = na;
      i_req = 1'b1; i_req_we = we; i_req_reg = r; i_req_data = d; i_keep_halt = keep;
      lat = 0; got_done = 1'b0;
      while (lat < 3000) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin
            i_req = 1'b0;
            check("busy_after_accept", o_busy, 1'b1);
         end
         if (poke && lat == 4) begin
            i_req = 1'b1; i_req_we = ~we; i_req_reg = ~r; i_req_data = ~d; i_keep_halt = ~keep;
         end
         if (lat == 5) i_req = 1'b0;
         if (o_done) begin
            got_done = 1'b1;
            break;
         end
      end
      check("done_seen", got_done, 1'b1);
      check("latency", lat, exp_lat);
      check("err", o_err, exp_err);
      check("busy_at_done", o_busy, 1'b0);
      if (!we && !exp_err) check("rdata", o_rdata, exp_rdata);
      if (na) check("timeout_cyc_len", cyc_len_last, 1 << TIMEOUT_LG);
      check("xfer_count", act_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
         check($sformatf("xfer%0d", i), act_q[i], exp_q[i]);
      noack = 1'b0;
      @(posedge clk); #1;
      check("done_one_pulse", o_done, 1'b0);
      check("no_extra_cyc", o_dbg_cyc, 1'b0);
   endtask

   initial begin
      int wait_cyc;
      for (int i = 0; i < 32; i++) begin
         cpu_regs[i] = $urandom; model_regs[i] = cpu_regs[i];
      end
      i_rst = 1'b1; i_req = 1'b0; i_req_we = 1'b0; i_req_reg = '0; i_req_data = '0; i_keep_halt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", o_busy, 1'b0);
      check("rst_done", o_done, 1'b0);
      check("rst_err", o_err, 1'b0);
      check("rst_rdata", o_rdata, 32'h0);
      check("rst_cyc_stb", {o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr}, 4'h0);
      check("rst_wdata", o_dbg_data, 32'h0);
      i_rst = 1'b0;
      @(posedge clk); #1;

      // Read reg 5 with CPU running, then halt-keeping read, then write while halted.
      run_req(1'b0, 5'd5, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);
      run_req(1'b0, 5'd7, 32'h0, 1'b1, 0, 0, 1'b0, 1'b0);
      run_req(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 0, 0, 1'b0, 1'b0);
      run_req(1'b0, 5'd3, 32'h0, 1'b0, 3, 0, 1'b0, 1'b0);
      run_req(1'b0, 5'd9, 32'h0, 1'b0, 9, 0, 1'b0, 1'b0);
      cpu_halt = 1'b0; model_halt = 1'b0;
      run_req(1'b1, 5'd12, 32'h1234_5678, 1'b0, 0, 7, 1'b0, 1'b1);
      run_req(1'b0, 5'd12, 32'h0, 1'b0, 1, 7, 1'b0, 1'b0);
      run_req(1'b0, 5'd1, 32'h0, 1'b0, 0, 0, 1'b1, 1'b0);

      // Abort with reset while polling, then a clean request.
      exp_q.delete(); act_q.delete();
      nr_cfg = 100; data_stall_cfg = 0;
      i_req = 1'b1; i_req_we = 1'b0; i_req_reg = 5'd4; i_keep_halt = 1'b0;
      @(posedge clk); #1;
      i_req = 1'b0;
      wait_cyc = 0;
      while (act_q.size() < 3 && wait_cyc < 50) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      check("reached_poll", act_q.size() >= 3, 1'b1);
      i_rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_cyc_stb", {o_dbg_cyc, o_dbg_stb}, 2'b00);
      check("rst_mid_busy_done", {o_busy, o_done}, 2'b00);
      i_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("no_done_after_rst", o_done, 1'b0);
      end
      model_halt = 1'b1;
      run_req(1'b0, 5'd4, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);

      for (int n = 0; n < 20; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            cpu_halt = 1'b0; model_halt = 1'b0;
         end
         run_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5), $urandom_range(0, 3),
                 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
